// File: rtl/matmul_pkg.sv
// Shared definitions for the memory-mapped matrix multiplier.
// Holds the sequencer state encoding, the address-source select codes,
// default parameter values and the row-major address helper.
package matmul_pkg;

  localparam int MEM_AW_DEF   = 16;
  localparam int MEM_DW_DEF   = 32;
  localparam int DIM_BITS_DEF = 16;
  localparam int PREC_DEF     = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_WT_A,
    S_RD_B,
    S_WT_B,
    S_MAC,
    S_WR_C,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SEL_A,
    SEL_B,
    SEL_C
  } addr_sel_t;

  // base + row*stride + col at 32 bits; callers truncate to the memory
  // address width, which gives the required wrap-around.
  function automatic logic [31:0] addr_expr(input logic [31:0] base,
                                            input logic [31:0] row,
                                            input logic [31:0] stride,
                                            input logic [31:0] col);
    return base + row * stride + col;
  endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// Loop counters and address generation for the matrix multiplier.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clr               clear i, j, k (start of a run)
//   inc_k             advance k (wraps to 0 after the last k)
//   inc_ij            advance j, carrying into i after the last j
//   sel               address source: SEL_A, SEL_B or SEL_C
//   *_base, *_stride  latched matrix placement
//   a_rows/a_cols/b_cols  latched dimensions
//   last_k, last_ij   loop terminal flags
//   addr              selected word address
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter int MEM_AW   = MEM_AW_DEF,
  parameter int DIM_BITS = DIM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc_k,
  input  logic                inc_ij,
  input  logic [1:0]          sel,
  input  logic [MEM_AW-1:0]   a_base,
  input  logic [MEM_AW-1:0]   b_base,
  input  logic [MEM_AW-1:0]   c_base,
  input  logic [DIM_BITS-1:0] a_stride,
  input  logic [DIM_BITS-1:0] b_stride,
  input  logic [DIM_BITS-1:0] c_stride,
  input  logic [DIM_BITS-1:0] a_rows,
  input  logic [DIM_BITS-1:0] a_cols,
  input  logic [DIM_BITS-1:0] b_cols,
  output logic                last_k,
  output logic                last_ij,
  output logic [MEM_AW-1:0]   addr
);

  localparam logic [DIM_BITS-1:0] ONE = DIM_BITS'(1);

  logic [DIM_BITS-1:0] i, j, k;
  logic                last_j;

  assign last_k  = (k == a_cols - ONE);
  assign last_j  = (j == b_cols - ONE);
  assign last_ij = last_j && (i == a_rows - ONE);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (inc_k) k <= last_k ? '0 : k + ONE;
      if (inc_ij) begin
        if (last_j) begin
          j <= '0;
          i <= i + ONE;
        end else begin
          j <= j + ONE;
        end
      end
    end
  end

  always_comb begin
    addr = '0;
    case (sel)
      SEL_A:   addr = MEM_AW'(addr_expr(32'(a_base), 32'(i), 32'(a_stride), 32'(k)));
      SEL_B:   addr = MEM_AW'(addr_expr(32'(b_base), 32'(k), 32'(b_stride), 32'(j)));
      default: addr = MEM_AW'(addr_expr(32'(c_base), 32'(i), 32'(c_stride), 32'(j)));
    endcase
  end

endmodule

// File: rtl/matmul_engine.sv
// Memory-mapped integer matrix multiplier, C = A x B.
// Walks i (rows of A), j (columns of B), k (inner) and issues one memory
// access at a time over a single-outstanding request/response port.
//
// state  | meaning
// IDLE   | waiting for go; latches configuration on start
// RD_A   | issue read of A[i][k]
// WT_A   | wait for A read data
// RD_B   | issue read of B[k][j]
// WT_B   | wait for B read data
// MAC    | acc += A*B, step k
// WR_C   | write acc to C[i][j], clear acc, step i/j
// DONE   | raise ret for one cycle
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   go, sm_ena                start request, sequencer enable (0 freezes)
//   aBASE/bBASE/cBASE         word addresses of element [0][0]
//   aSTRIDE/bSTRIDE/cSTRIDE   row pitch in words
//   aROWS/aCOLS/bCOLS         dimensions
//   mem_req/mem_write/mem_addr/mem_wdata   registered request outputs
//   mem_rdata_vld/mem_rdata   read response
//   ret                       one-cycle completion pulse
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int MEM_AW   = MEM_AW_DEF,
  parameter int MEM_DW   = MEM_DW_DEF,
  parameter int DIM_BITS = DIM_BITS_DEF,
  parameter int PREC     = PREC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic                sm_ena,
  input  logic [MEM_AW-1:0]   aBASE,
  input  logic [MEM_AW-1:0]   bBASE,
  input  logic [MEM_AW-1:0]   cBASE,
  input  logic [DIM_BITS-1:0] aSTRIDE,
  input  logic [DIM_BITS-1:0] bSTRIDE,
  input  logic [DIM_BITS-1:0] cSTRIDE,
  input  logic [DIM_BITS-1:0] aROWS,
  input  logic [DIM_BITS-1:0] aCOLS,
  input  logic [DIM_BITS-1:0] bCOLS,
  output logic                mem_req,
  output logic                mem_write,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [MEM_DW-1:0]   mem_wdata,
  input  logic                mem_rdata_vld,
  input  logic [MEM_DW-1:0]   mem_rdata,
  output logic                ret
);

  state_t              state, state_nx;
  logic [MEM_AW-1:0]   a_base_q, b_base_q, c_base_q;
  logic [DIM_BITS-1:0] a_stride_q, b_stride_q, c_stride_q;
  logic [DIM_BITS-1:0] a_rows_q, a_cols_q, b_cols_q;
  logic [PREC-1:0]     op_a, op_b;
  logic [MEM_DW-1:0]   acc, product;
  logic                got_q;
  logic                clr, inc_k, inc_ij, last_k, last_ij;
  logic [1:0]          sel;
  logic [MEM_AW-1:0]   gen_addr;
  logic                rd_wait, rd_done;
  logic                unused_rdata_hi;

  assign unused_rdata_hi = ^mem_rdata[MEM_DW-1:PREC];
  assign product = MEM_DW'(op_a) * MEM_DW'(op_b);
  assign rd_wait = (state == S_WT_A) || (state == S_WT_B);
  // got_q remembers a response that landed while frozen.
  assign rd_done = mem_rdata_vld || got_q;

  matmul_addr_gen #(
    .MEM_AW  (MEM_AW),
    .DIM_BITS(DIM_BITS)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .inc_k   (inc_k),
    .inc_ij  (inc_ij),
    .sel     (sel),
    .a_base  (a_base_q),
    .b_base  (b_base_q),
    .c_base  (c_base_q),
    .a_stride(a_stride_q),
    .b_stride(b_stride_q),
    .c_stride(c_stride_q),
    .a_rows  (a_rows_q),
    .a_cols  (a_cols_q),
    .b_cols  (b_cols_q),
    .last_k  (last_k),
    .last_ij (last_ij),
    .addr    (gen_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    inc_k    = 1'b0;
    inc_ij   = 1'b0;
    sel      = SEL_C;
    if (state == S_RD_A) sel = SEL_A;
    if (state == S_RD_B) sel = SEL_B;
    if (sm_ena) begin
      case (state)
        S_IDLE: if (go) begin
          clr = 1'b1;
          if (aROWS == '0 || bCOLS == '0) state_nx = S_DONE;
          else if (aCOLS == '0)           state_nx = S_WR_C;
          else                            state_nx = S_RD_A;
        end
        S_RD_A: state_nx = S_WT_A;
        S_WT_A: if (rd_done) state_nx = S_RD_B;
        S_RD_B: state_nx = S_WT_B;
        S_WT_B: if (rd_done) state_nx = S_MAC;
        S_MAC: begin
          inc_k    = 1'b1;
          state_nx = last_k ? S_WR_C : S_RD_A;
        end
        S_WR_C: begin
          inc_ij = 1'b1;
          if (last_ij)            state_nx = S_DONE;
          else if (a_cols_q == '0) state_nx = S_WR_C;
          else                    state_nx = S_RD_A;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ret        <= 1'b0;
      acc        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      got_q      <= 1'b0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      c_base_q   <= '0;
      a_stride_q <= '0;
      b_stride_q <= '0;
      c_stride_q <= '0;
      a_rows_q   <= '0;
      a_cols_q   <= '0;
      b_cols_q   <= '0;
    end else begin
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      ret       <= 1'b0;
      // Read data is captured even while frozen so it is not lost.
      if (rd_wait && mem_rdata_vld) begin
        if (state == S_WT_A) op_a <= mem_rdata[PREC-1:0];
        else                 op_b <= mem_rdata[PREC-1:0];
        got_q <= !sm_ena;
      end else if (sm_ena) begin
        got_q <= 1'b0;
      end
      if (sm_ena) begin
        case (state)
          S_IDLE: if (go) begin
            a_base_q   <= aBASE;
            b_base_q   <= bBASE;
            c_base_q   <= cBASE;
            a_stride_q <= aSTRIDE;
            b_stride_q <= bSTRIDE;
            c_stride_q <= cSTRIDE;
            a_rows_q   <= aROWS;
            a_cols_q   <= aCOLS;
            b_cols_q   <= bCOLS;
            acc        <= '0;
          end
          S_RD_A, S_RD_B: begin
            mem_req  <= 1'b1;
            mem_addr <= gen_addr;
          end
          S_MAC: acc <= acc + product;
          S_WR_C: begin
            mem_req   <= 1'b1;
            mem_write <= 1'b1;
            mem_addr  <= gen_addr;
            mem_wdata <= acc;
            acc       <= '0;
          end
          S_DONE: ret <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
module tb_matmul_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        sm_ena = 1'b1;
  logic [15:0] aBASE = '0, bBASE = '0, cBASE = '0;
  logic [15:0] aSTRIDE = '0, bSTRIDE = '0, cSTRIDE = '0;
  logic [15:0] aROWS = '0, aCOLS = '0, bCOLS = '0;
  logic        mem_req, mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rdata_vld = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        ret;

  always #5 clk = ~clk;

  matmul_engine dut (
    .clk(clk), .rst(rst), .go(go), .sm_ena(sm_ena),
    .aBASE(aBASE), .bBASE(bBASE), .cBASE(cBASE),
    .aSTRIDE(aSTRIDE), .bSTRIDE(bSTRIDE), .cSTRIDE(cSTRIDE),
    .aROWS(aROWS), .aCOLS(aCOLS), .bCOLS(bCOLS),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata_vld(mem_rdata_vld),
    .mem_rdata(mem_rdata), .ret(ret)
  );

  typedef struct {
    bit        wr;
    bit [15:0] addr;
    bit [31:0] data;
  } access_t;

  access_t   exp_q[$];
  access_t   cur_e;
  bit [31:0] mem     [65536];
  bit [31:0] ref_mem [65536];
  int        checks = 0, failures = 0;
  int        lat = 1, rd_cnt = 0;
  bit [31:0] rd_data;
  int        cyc_g = 0, ret_cnt = 0, ret_cyc = 0, acc_cnt = 0, go_cyc = 0;
  bit        ena_q = 1'b1;
  bit [15:0] last_wr_addr = '0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // Memory model: synchronous write on the request cycle, read data
  // returned lat cycles after the request. A pending response is not
  // cancelled by DUT reset on purpose.
  always @(posedge clk) begin
    cyc_g++;
    ena_q = sm_ena;
    mem_rdata_vld <= 1'b0;
    if (rd_cnt == 1) begin
      mem_rdata_vld <= 1'b1;
      mem_rdata     <= rd_data;
    end
    if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
    if (mem_req === 1'b1 && mem_write === 1'b0) begin
      if (lat <= 1) begin
        mem_rdata_vld <= 1'b1;
        mem_rdata     <= mem[mem_addr];
      end else begin
        rd_cnt  <= lat - 1;
        rd_data <= mem[mem_addr];
      end
    end
    if (mem_req === 1'b1 && mem_write === 1'b1) mem[mem_addr] = mem_wdata;
  end

  // Per-cycle compare of every access against the model's access list.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        acc_cnt++;
        if (mem_write) last_wr_addr = mem_addr;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_access actual=wr%0d@%0h required=none", mem_write, mem_addr);
        end else begin
          cur_e = exp_q.pop_front();
          checks--;
          chk("access", {mem_write, mem_addr, (mem_write ? mem_wdata : 32'h0)},
              {cur_e.wr, cur_e.addr, cur_e.data});
        end
      end
      if (ret) begin
        if (ret_cnt == 0) ret_cyc = cyc_g;
        ret_cnt++;
      end
      if (!ena_q) chk("frozen_quiet", {mem_req, ret}, 0);
    end
  end

  function automatic bit [15:0] ea(int unsigned base, int unsigned row,
                                   int unsigned stride, int unsigned col);
    return 16'(base + row * stride + col);
  endfunction

  task automatic do_run(input int ab, input int bb, input int cb,
                        input int as, input int bs, input int cs,
                        input int ar, input int ac, input int bc,
                        input int lat_i, input int frz_at, input int frz_len,
                        input int rst_at);
    bit [31:0] acc;
    bit [15:0] aa, ba, ca;
    int        cyc, mism;
    aBASE = 16'(ab); bBASE = 16'(bb); cBASE = 16'(cb);
    aSTRIDE = 16'(as); bSTRIDE = 16'(bs); cSTRIDE = 16'(cs);
    aROWS = 16'(ar); aCOLS = 16'(ac); bCOLS = 16'(bc);
    lat = lat_i;
    for (int a = 0; a < 65536; a++) ref_mem[a] = mem[a];
    exp_q.delete();
    for (int i = 0; i < ar; i++)
      for (int j = 0; j < bc; j++) begin
        acc = 0;
        for (int k = 0; k < ac; k++) begin
          aa = ea(ab, i, as, k);
          ba = ea(bb, k, bs, j);
          exp_q.push_back('{1'b0, aa, 32'h0});
          exp_q.push_back('{1'b0, ba, 32'h0});
          acc += {16'h0, ref_mem[aa][15:0]} * {16'h0, ref_mem[ba][15:0]};
        end
        ca = ea(cb, i, cs, j);
        exp_q.push_back('{1'b1, ca, acc});
        ref_mem[ca] = acc;
      end
    ret_cnt = 0;
    acc_cnt = 0;
    go_cyc  = cyc_g;
    go      = 1'b1;
    cyc     = 0;
    while (ret_cnt == 0 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      go = 1'b0;
      if (frz_len > 0 && cyc == frz_at) sm_ena = 1'b0;
      if (frz_len > 0 && cyc == frz_at + frz_len) sm_ena = 1'b1;
      if (rst_at > 0 && cyc == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        sm_ena = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        return;
      end
    end
    sm_ena = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("ret_pulses", ret_cnt, 1);
    chk("accesses_left", exp_q.size(), 0);
    mism = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] != ref_mem[a]) mism++;
    chk("mem_image_mismatches", mism, 0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = a;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_ret", ret, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reference run
    do_run('h100, 'h200, 'h300, 4, 5, 8, 6, 4, 5, 1, 0, 0, 0);
    chk("c00_literal", mem[16'h300], 535110);
    chk("c01_literal", mem[16'h301], 536140);
    for (int a = 'h305; a <= 'h307; a++) chk("c_gap_untouched", mem[a], a);

    // Freeze for 20 cycles mid-run
    do_run('h100, 'h200, 'h300, 4, 5, 8, 6, 4, 5, 1, 100, 20, 0);
    chk("freeze_c00", mem[16'h300], 535110);

    // Reset mid-run, then a fresh run
    do_run('h100, 'h200, 'h300, 4, 5, 8, 6, 4, 5, 1, 0, 0, 150);
    do_run('h100, 'h200, 'h300, 4, 5, 8, 6, 4, 5, 1, 0, 0, 0);
    chk("after_rst_c00", mem[16'h300], 535110);

    // aCOLS = 0 fills C with zeros
    do_run('h100, 'h200, 'h400, 4, 5, 8, 3, 0, 2, 1, 0, 0, 0);
    chk("acols0_c00", mem[16'h400], 0);
    chk("acols0_c21", mem[16'h411], 0);

    // aROWS = 0: no accesses, ret two cycles after go
    do_run('h100, 'h200, 'h300, 4, 5, 8, 0, 4, 5, 1, 0, 0, 0);
    chk("arows0_accesses", acc_cnt, 0);
    chk("arows0_ret_latency", ret_cyc - go_cyc, 2);

    // Three-cycle read latency
    do_run('h100, 'h200, 'h500, 4, 5, 8, 6, 4, 5, 3, 0, 0, 0);
    chk("lat3_c00", mem[16'h500], 535110);

    // C address wrap
    do_run('h100, 'h200, 'hFFFE, 4, 5, 8, 1, 2, 3, 1, 0, 0, 0);
    chk("wrap_c00", mem[16'hFFFE], 263941);
    chk("wrap_last_write_addr", last_wr_addr, 0);

    // Randomized runs on random memory contents
    for (int a = 0; a < 65536; a++) mem[a] = $urandom;
    for (int r = 0; r < 6; r++) begin
      do_run($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535),
             $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
             $urandom_range(1, 4), $urandom_range(0, 4), $urandom_range(1, 4),
             $urandom_range(1, 3), $urandom_range(5, 30), $urandom_range(0, 15), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_engine.md
Name: matmul_engine

Overview:
- Memory-mapped integer matrix multiplier: C = A×B.
- A, B and C live in one word-addressed memory and are reached over a single-outstanding request/response port.
- A host programs base, stride and dimension inputs, pulses go, and waits for a one-cycle ret.
- sm_ena can freeze the sequencer at any point; the memory model (mem) is a separate block on the same port.

Parameters:
- MEM_AW, 16, memory word-address width.
- MEM_DW, 32, memory data width; accumulator and C element width.
- DIM_BITS, 16, width of dimension and stride inputs.
- PREC, 16, operand precision; A and B use the low PREC bits of each word.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start request, level-sampled in IDLE.
- sm_ena  in  1  sequencer enable; 0 freezes all state.
- aBASE/bBASE/cBASE  in  MEM_AW  word addresses of A[0][0], B[0][0], C[0][0].
- aSTRIDE/bSTRIDE/cSTRIDE  in  DIM_BITS  row pitch of each matrix, in words.
- aROWS  in  DIM_BITS  rows of A and of C.
- aCOLS  in  DIM_BITS  columns of A and rows of B.
- bCOLS  in  DIM_BITS  columns of B and of C.
- mem_req  out  1  request strobe, one cycle per access.
- mem_write  out  1  1 = write, 0 = read; qualified by mem_req.
- mem_addr  out  MEM_AW  access word address.
- mem_wdata  out  MEM_DW  write data.
- mem_rdata_vld  in  1  read-data valid.
- mem_rdata  in  MEM_DW  read data.
- ret  out  1  one-cycle done pulse.

Behaviour:
- Reset values:
  - mem_req, mem_write, ret = 0; mem_addr, mem_wdata = 0.
  - State = IDLE; i, j, k, acc = 0.
- IDLE: when go=1 and sm_ena=1, latch all base, stride and dimension inputs, clear i, j, k and acc, and start. go is ignored outside IDLE.
- Loop order: i = 0..aROWS-1 (outer), j = 0..bCOLS-1, k = 0..aCOLS-1 (inner).
- For each k:
  - Read A at aBASE + i*aSTRIDE + k.
  - Read B at bBASE + k*bSTRIDE + j.
  - acc += A[PREC-1:0] * B[PREC-1:0].
- After the last k, write acc to cBASE + i*cSTRIDE + j, then clear acc.
- Arithmetic:
  - Addresses are computed at full width and truncated to MEM_AW (wrap).
  - Operands are unsigned; the product and acc are modulo 2^MEM_DW.
- State machine: IDLE → RD_A → WT_A → RD_B → WT_B → MAC → (next k: RD_A | last k: WR_C) → (more i,j: RD_A | done: DONE) → IDLE.
  - DONE asserts ret for exactly one cycle.
- Handshake:
  - mem_req is high for exactly one cycle per access, with address, write and wdata valid in that cycle.
  - Only one read is outstanding; the WT_* states hold until mem_rdata_vld=1, with any latency of 1 cycle or more.
  - Writes complete in the request cycle.
- sm_ena=0:
  - No state, counter or acc change; mem_req forced 0; ret held 0 (a pending DONE waits).
  - A mem_rdata_vld arriving while frozen is still captured into the operand register and consumed on resume.
- Degenerate sizes:
  - aROWS=0 or bCOLS=0: no memory accesses; ret 2 cycles after start.
  - aCOLS=0: every C element is written as 0.
- Reset mid-operation returns to IDLE within one cycle; no further requests, and any stale rdata_vld is ignored.
- go still high when the block returns to IDLE after DONE starts a new run.
- mem model (bench side):
  - 2^MEM_AW words.
  - Write is synchronous on the mem_req cycle.
  - Read returns mem_rdata with mem_rdata_vld exactly one cycle after the request.

Decomposition:
- Shared package matmul_pkg: state enum, default parameter constants, and a helper function for the address expression base + row*stride + col.
- One natural sub-module, matmul_addr_gen: the i/j/k counters plus address muxing for A, B and C.

Test Plan:
- mem[a]=a, aBASE=0x100, bBASE=0x200, cBASE=0x300, aROWS=6, aCOLS=4, bCOLS=5, aSTRIDE=4, bSTRIDE=5, cSTRIDE=8, go pulsed → all 30 C elements match a golden model; C[0][0]=535110; ret pulses exactly once; words 0x305–0x307 are untouched.
- Same run with sm_ena=0 for 20 cycles mid-run → identical C; no mem_req while frozen.
- Reset asserted mid-run, then a new go → no stale writes; correct result.
- aCOLS=0 → C region filled with 0; aROWS=0 → zero memory accesses and ret in 2 cycles.
- Read latency stretched to 3 cycles in the mem model → same correct C.
- Address wrap: cBASE=0xFFFE with a 1×3 C → writes land at 0xFFFE, 0xFFFF, 0x0000.
